// File: rtl/eth_fcs_appender.sv
// eth_fcs_appender: pads frames to MIN_FRAME, appends CRC-32 FCS, enforces IFG.
// in_*: byte stream (valid/ready/first/last); out_*: byte stream; err_oversize: truncation pulse.
module eth_fcs_appender #(
  parameter int MIN_FRAME = 60,
  parameter int MAX_FRAME = 1514,
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_first,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       err_oversize
);

  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;
  localparam logic [10:0] MIN_C = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_C = 11'(MAX_FRAME);
  localparam int IW = $clog2(IFG_BYTES + 1);
  localparam logic [IW-1:0] IFG_END = IW'(IFG_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS,
    S_PAD,
    S_FCS,
    S_DROP,
    S_IFG
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]   crc;
  logic [31:0]   crc_nxt;
  logic [10:0]   byte_cnt;
  logic [10:0]   cnt_inc;
  logic [1:0]    fcs_idx;
  logic [IW-1:0] ifg_cnt;
  logic          trunc;

  logic       load;
  logic       acc;
  logic       emit;
  logic       emit_last;
  logic [7:0] emit_data;
  logic [7:0] fcs_byte;
  logic       crc_en;
  logic       oversize_hit;

  // Reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign load    = !out_valid || out_ready;
  assign acc     = in_valid && in_ready;
  assign cnt_inc = byte_cnt + 11'd1;
  assign crc_nxt = crc_byte(crc, emit_data);
  assign crc_en  = emit && (state != S_FCS);

  // The MAX_FRAME-th byte with in_last is a normal end, not a truncation.
  assign oversize_hit = (state == S_PASS) && acc
                     && !in_last && (cnt_inc == MAX_C);

  always_comb begin
    fcs_byte = ~crc[7:0];
    unique case (1'b1)
      (fcs_idx == 2'd0): fcs_byte = ~crc[7:0];
      (fcs_idx == 2'd1): fcs_byte = ~crc[15:8];
      (fcs_idx == 2'd2): fcs_byte = ~crc[23:16];
      (fcs_idx == 2'd3): fcs_byte = ~crc[31:24];
      default:           fcs_byte = ~crc[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (acc && in_first) begin
          if (!in_last) begin
            state_nxt = S_PASS;
          end else if (11'd1 < MIN_C) begin
            state_nxt = S_PAD;
          end else begin
            state_nxt = S_FCS;
          end
        end
      end
      S_PASS: begin
        if (acc) begin
          if (in_last) begin
            state_nxt = (cnt_inc < MIN_C) ? S_PAD : S_FCS;
          end else if (cnt_inc == MAX_C) begin
            state_nxt = S_FCS;
          end
        end
      end
      S_PAD: begin
        if (load && (cnt_inc == MIN_C)) begin
          state_nxt = S_FCS;
        end
      end
      S_FCS: begin
        if (load && (fcs_idx == 2'd3)) begin
          state_nxt = trunc ? S_DROP : S_IFG;
        end
      end
      S_DROP: begin
        if (acc && in_last) begin
          state_nxt = S_IFG;
        end
      end
      S_IFG: begin
        if (load && (ifg_cnt == IFG_END)) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    emit      = 1'b0;
    emit_data = in_data;
    emit_last = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = load;
        emit     = acc && in_first;
      end
      S_PASS: begin
        in_ready = load;
        emit     = acc;
      end
      S_PAD: begin
        emit      = load;
        emit_data = 8'h00;
      end
      S_FCS: begin
        emit      = load;
        emit_data = fcs_byte;
        emit_last = (fcs_idx == 2'd3);
      end
      S_DROP: begin
        in_ready = 1'b1;
      end
      S_IFG: begin
        in_ready = 1'b0;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= 8'h00;
      out_last     <= 1'b0;
      err_oversize <= 1'b0;
      crc          <= INIT;
      byte_cnt     <= 11'd0;
      fcs_idx      <= 2'd0;
      ifg_cnt      <= '0;
      trunc        <= 1'b0;
    end else begin
      err_oversize <= oversize_hit;
      if (load) begin
        out_valid <= emit;
        out_last  <= emit_last;
        if (emit) begin
          out_data <= emit_data;
        end
      end
      if (crc_en) begin
        crc <= crc_nxt;
      end
      if (oversize_hit) begin
        trunc <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (emit) begin
            byte_cnt <= 11'd1;
          end
        end
        S_PASS, S_PAD: begin
          if (emit) begin
            byte_cnt <= cnt_inc;
          end
        end
        S_FCS: begin
          if (emit) begin
            fcs_idx <= fcs_idx + 2'd1;
          end
        end
        S_IFG: begin
          // Gap counts free output slots, so it starts as the last FCS byte drains.
          if (load) begin
            if (ifg_cnt == IFG_END) begin
              ifg_cnt  <= '0;
              crc      <= INIT;
              byte_cnt <= 11'd0;
              trunc    <= 1'b0;
            end else begin
              ifg_cnt <= ifg_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_fcs_appender.sv
// tb_eth_fcs_appender: scoreboard bench for eth_fcs_appender.
// Expected bytes are queued at stimulus time; a monitor pops them on output handshakes.
module tb_eth_fcs_appender;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_first = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       err_oversize;

  eth_fcs_appender dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_first     (in_first),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .err_oversize (err_oversize)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  frm[$];
  int          checks = 0;
  int          errors = 0;
  int          err_pulses = 0;
  int          flush_cnt = 0;
  int          seen_flush = 0;
  logic        bp_mode = 1'b0;
  logic [31:0] mon_crc = 32'hFFFFFFFF;
  logic [31:0] fcs_sh = 32'h0;
  logic [31:0] last_fcs = 32'h0;
  logic        stall = 1'b0;
  logic [7:0]  st_d = 8'h00;
  logic        st_l = 1'b0;
  exp_t        e;

  // Bit-serial reference CRC: one message bit per step.
  function automatic logic [31:0] crc_model(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic mk_frame(input int len, input int seed);
    frm.delete();
    for (int i = 0; i < len; i++) begin
      frm.push_back(8'((i * seed + 3 * seed + 1) & 255));
    end
  endtask

  task automatic push_frame();
    logic [7:0]  o[$];
    logic [31:0] c;
    int          n;
    n = (frm.size() > 1514) ? 1514 : frm.size();
    for (int i = 0; i < n; i++) o.push_back(frm[i]);
    while (o.size() < 60) o.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (o[i]) c = crc_model(c, o[i]);
    c = ~c;
    foreach (o[i]) sb.push_back('{d: o[i], l: 1'b0});
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{d: c[8*k +: 8], l: (k == 3)});
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic f,
                           input logic l, input logic lat);
    int   w;
    logic acc;
    w = 0;
    acc = 1'b0;
    in_data = d;
    in_first = f;
    in_last = l;
    in_valid = 1'b1;
    while (!acc && w < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      w++;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
    chk("accept", {31'b0, acc}, 32'd1);
    if (acc && lat) begin
      chk("lat_valid", {31'b0, out_valid}, 32'd1);
      chk("lat_data", {24'b0, out_data}, {24'b0, d});
    end
  endtask

  task automatic send_frame();
    int n;
    n = frm.size();
    push_frame();
    for (int i = 0; i < n; i++) begin
      send_byte(frm[i], (i == 0), (i == n - 1), (i < 1514));
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 5000) begin
      @(posedge clk);
      w++;
    end
    chk("drain", sb.size(), 32'd0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? ~out_ready : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (seen_flush != flush_cnt) begin
        seen_flush = flush_cnt;
        mon_crc = 32'hFFFFFFFF;
        stall = 1'b0;
      end
      if (err_oversize) err_pulses++;
      if (stall) begin
        checks++;
        if (!out_valid || out_data !== st_d || out_last !== st_l) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                   out_valid, out_data, out_last, st_d, st_l);
        end
      end
      stall = out_valid && !out_ready;
      st_d = out_data;
      st_l = out_last;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got d=%h l=%b, required no output",
                   out_data, out_last);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            errors++;
            $display("FAIL out_byte: got d=%h l=%b, required d=%h l=%b",
                     out_data, out_last, e.d, e.l);
          end
        end
        mon_crc = crc_model(mon_crc, out_data);
        fcs_sh = {out_data, fcs_sh[31:8]};
        if (out_last) begin
          chk("residue", mon_crc, 32'hDEBB20E3);
          last_fcs = fcs_sh;
          mon_crc = 32'hFFFFFFFF;
        end
      end
    end
  end

  initial begin
    int          n;
    int          p0;
    logic [31:0] fcs_ok;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {24'b0, out_data}, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_err", {31'b0, err_oversize}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    mk_frame(64, 3);
    send_frame();
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("ifg_ready_low", n, 32'd16);
    drain();

    mk_frame(24, 11);
    send_frame();
    drain();

    mk_frame(100, 5);
    send_frame();
    drain();
    fcs_ok = last_fcs;
    bp_mode = 1'b1;
    send_frame();
    drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_fcs", last_fcs, fcs_ok);

    p0 = err_pulses;
    mk_frame(1600, 7);
    send_frame();
    drain();
    chk("oversize_pulse", err_pulses - p0, 32'd1);
    mk_frame(64, 9);
    send_frame();
    drain();

    p0 = err_pulses;
    mk_frame(1514, 13);
    send_frame();
    drain();
    chk("max_no_pulse", err_pulses - p0, 32'd0);

    mk_frame(64, 17);
    push_frame();
    for (int i = 0; i < 29; i++) begin
      send_byte(frm[i], (i == 0), 1'b0, 1'b1);
    end
    in_data = frm[29];
    in_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    flush_cnt++;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    mk_frame(60, 19);
    send_frame();
    drain();

    for (int i = 0; i < 3; i++) begin
      send_byte(8'h55 + 8'(i), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("stray_no_out", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    frm.delete();
    frm.push_back(8'hAA);
    send_frame();
    drain();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_fcs_appender.md
# eth_fcs_appender

Downstream stage of the Ethernet frame generator. It consumes the byte stream covering destination MAC through the end of payload, one byte per transfer. It pads short frames to the 60-byte minimum and computes the IEEE 802.3 CRC-32 over all emitted bytes. It then appends the 4-byte FCS and enforces an inter-frame gap before accepting the next frame. Preamble/SFD are not seen by this block.

## Interface
- MIN_FRAME, 60: minimum bytes (dest..pad) before FCS.
- MAX_FRAME, 1514: maximum bytes (dest..payload) before forced truncation.
- IFG_BYTES, 12: idle cycles after the last FCS byte.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  8  input byte.
- in_valid  in  1  input byte valid.
- in_first  in  1  byte is the first destination-MAC byte.
- in_last  in  1  byte is the last payload byte.
- in_ready  out  1  block accepts the input byte this cycle.
- out_data  out  8  output byte.
- out_valid  out  1  output byte valid.
- out_last  out  1  output byte is the final FCS byte.
- out_ready  in  1  sink accepts the output byte.
- err_oversize  out  1  one-cycle pulse on truncation.

## Operation
- Transfers: input accepted when in_valid&&in_ready; output consumed when out_valid&&out_ready.
- Output is a single registered stage. It may load when !out_valid||out_ready. out_data/out_last are held stable while out_valid&&!out_ready.
- States: IDLE, PASS, PAD, FCS, DROP, IFG.
- IDLE: in_ready = output may load.
  - Accepted byte with in_first=1: emitted, crc updated, byte_cnt=1. Go to PASS, or to PAD/FCS if in_last=1 as well.
  - Accepted byte with in_first=0: discarded. No output, no state change.
- PASS: in_ready = output may load. Each accepted byte is emitted, crc updated, byte_cnt incremented. in_first is ignored in PASS.
  - On in_last: go to PAD if byte_cnt (including this byte) < MIN_FRAME, else FCS.
  - When byte_cnt reaches MAX_FRAME without in_last: pulse err_oversize with that byte's acceptance, go to FCS, then DROP.
- PAD: in_ready=0. Emit 0x00 bytes, each updating crc and byte_cnt, until byte_cnt==MIN_FRAME. Then go to FCS.
- FCS: in_ready=0. Emit ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24], using fcs_idx 0..3. out_last=1 on the 4th byte. After it is loaded, go to DROP if truncated, else IFG.
- DROP: in_ready=1. Accept and discard bytes until one with in_last. Then go to IFG.
- IFG: in_ready=0. Count IFG_BYTES cycles starting after the last FCS byte is consumed by the sink. Then go to IDLE and reinitialise crc to 0xFFFFFFFF.
- CRC rules:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Bytes are processed LSB-first, one byte per cycle, in a combinational 8-step update.
  - Update only on byte load into the output register, never on stall cycles.
- byte_cnt: 11 bits, cleared in IDLE; never exceeds MAX_FRAME.

## Timing
- Reset values:
  - state=IDLE, crc=0xFFFFFFFF, byte_cnt=0, fcs_idx=0, ifg_cnt=0.
  - out_valid=0, out_data=0x00, out_last=0, err_oversize=0.
  - in_ready=1 in the first cycle after reset.
- Reset mid-frame: the partial frame is abandoned with no FCS. Outputs return to reset values the next cycle.
- Latency: a byte accepted in cycle N is on out_data in cycle N+1.
- With out_ready=1, PAD and FCS bytes follow the last input byte back-to-back with no bubble.
- Total output per frame = max(L, MIN_FRAME)+4 bytes, where L is the input length (L capped at MAX_FRAME).
- Residue: CRC register run over emitted data plus FCS equals 0xDEBB20E3.
- in_last together with the MAX_FRAME-th byte is a normal end: no err_oversize, no DROP.

## Test plan
- 64-byte frame, out_ready=1:
  - 68 output bytes; the first 64 are equal to the input, delayed 1 cycle.
  - FCS matches the bench CRC model; residue is 0xDEBB20E3.
  - in_ready stays low for 4+12 cycles after in_last.
- 24-byte frame (14-byte header + 10-byte payload): 36 bytes of 0x00 padding, 64 output bytes, out_last on byte 64 only.
- Backpressure: 100-byte frame with out_ready toggling 1,0,1,0:
  - No byte lost or duplicated.
  - out_data is stable during stalls.
  - FCS is identical to the out_ready=1 run.
- Oversize: 1600 bytes, in_last on byte 1600:
  - 1514 bytes passed, then 4 FCS bytes.
  - err_oversize pulses exactly once.
  - Remaining 86 bytes are accepted and discarded.
  - The following 64-byte frame is correct.
- Reset asserted at input byte 30:
  - Next cycle: out_valid=0, in_ready=1.
  - A subsequent 60-byte frame produces a correct FCS.
- Edge inputs:
  - 3 stray bytes with in_first=0 in IDLE are discarded with no output.
  - A single byte 0xAA with in_first=1 and in_last=1 gives 0xAA, 59 bytes of 0x00, then 4 FCS bytes.
